instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Clocked fetch stage directly upstream of the asynchronous instruction register.
//  - Owns the program counter and reads one 14-bit payload per instruction from program memory.
//  - Presents each instruction as {phase tag, payload} with a matching phase code.
//  - Runs a 4-phase return-to-null handshake against the register's acknowledge.
// PARAMETERS
//  ADDR_W     8      program counter / memory address width
//  RESET_PC   0      PC value loaded on reset
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  halt         in   1       1 = stop issuing after current word completes
//  redirect     in   1       1-cycle pulse: load redirect_pc as next fetch address
//  redirect_pc  in   ADDR_W  redirect target
//  mem_addr     out  ADDR_W  program memory address (= pc)
//  mem_rd       out  1       read request, held until mem_ready
//  mem_ready    in   1       read data valid this cycle
//  mem_rdata    in   14      instruction payload
//  data_out     out  16      {tag[1:0], payload[13:0]} to instruction register data
//  ph1_out      out  2       phase code to instruction register PH1
//  ack_in       in   1       acknowledge from instruction register (its ack_befo)
//  pc_out       out  ADDR_W  address of word currently presented
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, state=IDLE, data_out=16'h0000, ph1_out=2'b00, mem_rd=0,
//     next tag=2'b01, redirect pending cleared, pc_out=RESET_PC.
//   - Reset mid-handshake aborts it; data_out drops to null immediately.
//  Tags:
//   - Valid words alternate 2'b01, 2'b10, starting at 2'b01; 2'b00 = null; 2'b11 never driven.
//  FSM:
//   - IDLE: halt=0 -> FETCH next cycle.
//   - FETCH: mem_rd=1, mem_addr=pc. On mem_ready, capture mem_rdata -> PRESENT.
//   - PRESENT: data_out={tag,payload}, ph1_out=tag, pc_out=pc. Wait ack_s=1 -> RELEASE.
//   - RELEASE: data_out={2'b00,payload}; ph1_out holds tag. Wait ack_s=0, then:
//     - pc <= pending redirect target if one is latched, else pc+1;
//     - tag toggles;
//     - go to IDLE if halt=1, else FETCH.
//  ack_s: the acknowledge as seen by the FSM (see CONFIGURATION).
//  Latency:
//   - Without IFETCH_ACK_SYNC_EN: 1 cycle from ack_s edge to state change;
//     minimum 4 cycles per word with mem_ready=1 in the first FETCH cycle.
//  Redirect:
//   - In IDLE/FETCH: pc <= redirect_pc next cycle. An outstanding read restarts
//     (mem_rd stays 1 at the new address).
//   - redirect coincident with mem_ready: redirect wins, data discarded, stay in FETCH.
//   - In PRESENT/RELEASE: target latched as pending and applied at RELEASE exit.
//     A newer redirect overwrites the pending one.
//  Boundaries:
//   - pc wraps 2^ADDR_W-1 -> 0.
//   - ack_s=1 seen in FETCH/IDLE is ignored.
//   - halt sampled only in IDLE and at RELEASE exit; never truncates a handshake.
// CONFIGURATION
//  IFETCH_ACK_SYNC_EN defined:
//   - ack_in passes a 2-flop synchronizer before use, so ack_in may be fully asynchronous.
//   - Adds 2 cycles to each ack edge; minimum 8 cycles per word.
//  Not defined:
//   - ack_s = ack_in directly; ack_in must be synchronous to clk.
// STRUCTURE
//  Package ifetch_pkg:
//   - state encoding IDLE/FETCH/PRESENT/RELEASE;
//   - TAG_NULL=2'b00, TAG_A=2'b01, TAG_B=2'b10;
//   - PAYLOAD_W=14.
//  Sub-module ack_sync: 2-flop synchronizer with rst_n, instantiated only under the macro.
// TESTING
//  T1 reset, mem_ready=1, ack follows data 1 cycle later
//     -> words at pc 0,1,2 with tags 01,10,01; data_out nulls between words.
//  T2 redirect=1, redirect_pc=8'h40 during PRESENT of pc=5
//     -> word at 5 completes, next mem_addr=8'h40, tag toggles normally.
//  T3 redirect to 8'h20 in the same cycle as mem_ready at pc=3
//     -> payload discarded, next presented word comes from pc=8'h20.
//  T4 RESET_PC=8'hFF, two handshakes
//     -> second word fetched from pc=8'h00.
//  T5 halt=1 asserted mid-PRESENT
//     -> handshake completes, FSM in IDLE, mem_rd=0; halt=0 resumes at pc+1.
//  T6 rst_n pulsed low in RELEASE
//     -> data_out=0, ph1_out=0 immediately; first word after release is RESET_PC with tag 01.
//     Rerun T1 with IFETCH_ACK_SYNC_EN: identical sequence, 8 cycles per word.

Source files
------------

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch stage
package ifetch_pkg;

  localparam int PAYLOAD_W = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] TAG_NULL = 2'b00;
  localparam logic [1:0] TAG_A    = 2'b01;
  localparam logic [1:0] TAG_B    = 2'b10;

  // Valid words alternate A/B; anything else restarts at A
  function automatic logic [1:0] next_tag(input logic [1:0] tag);
    return (tag == TAG_A) ? TAG_B : TAG_A;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - program memory bus and instruction register handshake
interface instr_fetch_if #(
  parameter int ADDR_W = 8
);
  import ifetch_pkg::*;

  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_rd;
  logic                 mem_ready;
  logic [PAYLOAD_W-1:0] mem_rdata;
  logic [15:0]          data_out;
  logic [1:0]           ph1_out;
  logic                 ack_in;
  logic [ADDR_W-1:0]    pc_out;

  modport master (
    output mem_addr, mem_rd, data_out, ph1_out, pc_out,
    input  mem_ready, mem_rdata, ack_in
  );

  modport slave (
    input  mem_addr, mem_rd, data_out, ph1_out, pc_out,
    output mem_ready, mem_rdata, ack_in
  );

endinterface

// File: rtl/ack_sync.sv
// rtl/ack_sync.sv - two-flop synchronizer for the asynchronous acknowledge
module ack_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops let a metastable first stage settle before use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage with 4-phase handshake; IFETCH_ACK_SYNC_EN adds ack synchronizer
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_if.master     bus
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [1:0]           tag_q, tag_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 pend_q, pend_d;
  logic [ADDR_W-1:0]    pend_pc_q, pend_pc_d;
  logic                 ack_s;

`ifdef IFETCH_ACK_SYNC_EN
  ack_sync u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.ack_in),
    .q_o   (ack_s)
  );
`else
  assign ack_s = bus.ack_in;
`endif

  // State and datapath registers; reset aborts any handshake in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      tag_q     <= TAG_A;
      payload_q <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tag_q     <= tag_d;
      payload_q <= payload_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next-state logic: redirects act at once outside a handshake, deferred inside one
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tag_d     = tag_q;
    payload_d = payload_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) pc_d = redirect_pc;
        if (!halt) state_d = FETCH;
      end
      FETCH: begin
        // A redirect beats returning data: the read restarts at the new address
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (bus.mem_ready) begin
          payload_d = bus.mem_rdata;
          state_d   = PRESENT;
        end
      end
      PRESENT: begin
        if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
        if (ack_s) state_d = RELEASE;
      end
      RELEASE: begin
        if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
        if (!ack_s) begin
          // The newest redirect, even one arriving this cycle, picks the next pc
          if (redirect)    pc_d = redirect_pc;
          else if (pend_q) pc_d = pend_pc_q;
          else             pc_d = pc_q + PC_ONE;
          pend_d  = 1'b0;
          tag_d   = next_tag(tag_q);
          state_d = halt ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset nulls them without waiting for a clock
  always_comb begin
    bus.data_out = 16'h0000;
    bus.ph1_out  = TAG_NULL;
    case (state_q)
      PRESENT: begin
        bus.data_out = {tag_q, payload_q};
        bus.ph1_out  = tag_q;
      end
      RELEASE: begin
        bus.data_out = {TAG_NULL, payload_q};
        bus.ph1_out  = tag_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_rd   = (state_q == FETCH);
  assign bus.mem_addr = pc_q;
  assign bus.pc_out   = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized scoreboard bench for instr_fetch
module tb_instr_fetch;
  import ifetch_pkg::*;

  localparam int         ADDR_W   = 8;
  localparam logic [7:0] RESET_PC = 8'hFF;
`ifdef IFETCH_ACK_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       halt;
  logic       redirect;
  logic [7:0] redirect_pc;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] memf(input logic [7:0] a);
    logic [13:0] r;
    r = {6'b0, a} * 14'd97 + 14'd1234;
    return r ^ 14'h2A5;
  endfunction

  assign bus.mem_rdata = memf(bus.mem_addr);

  typedef struct {
    logic [1:0]  tag;
    logic [13:0] pl;
    logic [7:0]  pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] m_pc;
  logic [1:0] m_tag;
  bit         m_pend;
  logic [7:0] m_pend_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops an expected word whenever a fresh word appears on data_out
  logic [1:0] mon_prev;
  exp_t       mon_last;
  bit         mon_have;
  always @(negedge clk) begin
    logic [1:0] cur;
    if (!rst_n) begin
      mon_prev = TAG_NULL;
      mon_have = 0;
    end else begin
      cur = bus.data_out[15:14];
      if (cur == 2'b11) check("tag_11", {30'b0, cur}, 32'h1);
      if (mon_prev == TAG_NULL && cur != TAG_NULL) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {16'b0, bus.data_out}, 32'hFFFF_FFFF);
        end else begin
          mon_last = exp_q.pop_front();
          mon_have = 1;
          check("word_data", {16'b0, bus.data_out}, {16'b0, mon_last.tag, mon_last.pl});
          check("word_ph1", {30'b0, bus.ph1_out}, {30'b0, mon_last.tag});
          check("word_pc", {24'b0, bus.pc_out}, {24'b0, mon_last.pc});
        end
      end else if (mon_prev != TAG_NULL && cur == TAG_NULL && mon_have) begin
        check("release_payload", {18'b0, bus.data_out[13:0]}, {18'b0, mon_last.pl});
        check("release_ph1", {30'b0, bus.ph1_out}, {30'b0, mon_last.tag});
      end
      mon_prev = cur;
    end
  end

  task automatic step();
    @(negedge clk);
    redirect      = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic hs_redirect();
    redirect    = 1'b1;
    redirect_pc = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    m_pend      = 1;
    m_pend_pc   = redirect_pc;
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_tag  = TAG_A;
    m_pend = 0;
  endtask

  // One full word: fetch (with random stalls/redirects), present, release
  task automatic do_word(input bit allow_halt, input bit do_reset);
    int  g;
    int  r;
    bit  do_halt;
    g = 0;
    forever begin
      step();
      if (bus.mem_rd) begin
        r = $urandom_range(0, 9);
        if (r < 2) begin
          bus.ack_in    = 1'b0;
          redirect      = 1'b1;
          redirect_pc   = 8'($urandom_range(0, 255));
          bus.mem_ready = 1'($urandom_range(0, 1));
          m_pc          = redirect_pc;
        end else if (r < 4) begin
          bus.ack_in = (r == 3) && !SYNC;
        end else begin
          bus.ack_in = 1'b0;
          check("fetch_addr", {24'b0, bus.mem_addr}, {24'b0, m_pc});
          bus.mem_ready = 1'b1;
          exp_q.push_back('{tag: m_tag, pl: memf(m_pc), pc: m_pc});
          break;
        end
      end
      if (++g > 60) begin check("fetch_timeout", 32'(g), 32'h0); return; end
    end
    g = 0;
    do begin
      step();
      if (++g > 60) begin check("present_timeout", 32'(g), 32'h0); return; end
    end while (bus.data_out[15:14] == TAG_NULL);
    do_halt = allow_halt && ($urandom_range(0, 3) == 0);
    if (do_halt) halt = 1'b1;
    repeat ($urandom_range(0, 3)) begin
      step();
      if ($urandom_range(0, 3) == 0) hs_redirect();
    end
    step();
    bus.ack_in = 1'b1;
    if ($urandom_range(0, 4) == 0) hs_redirect();
    g = 0;
    do begin
      step();
      if (++g > 60) begin check("release_timeout", 32'(g), 32'h0); return; end
    end while (bus.data_out[15:14] != TAG_NULL);
    if (do_reset) begin
      #2 rst_n = 1'b0;
      #1 check("rst_async_data", {16'b0, bus.data_out}, 32'h0);
      check("rst_async_ph1", {30'b0, bus.ph1_out}, 32'h0);
      bus.ack_in = 1'b0;
      halt       = 1'b0;
      repeat (2) step();
      check("rst_mem_rd", {31'b0, bus.mem_rd}, 32'h0);
      check("rst_pc_out", {24'b0, bus.pc_out}, {24'b0, RESET_PC});
      #2 rst_n = 1'b1;
      model_reset();
      return;
    end
    repeat ($urandom_range(0, 3)) begin
      step();
      if ($urandom_range(0, 3) == 0) hs_redirect();
    end
    step();
    bus.ack_in = 1'b0;
    if ($urandom_range(0, 4) == 0) hs_redirect();
    m_pc   = m_pend ? m_pend_pc : m_pc + 8'd1;
    m_pend = 0;
    m_tag  = (m_tag == TAG_A) ? TAG_B : TAG_A;
    if (do_halt) begin
      repeat (4) step();
      check("halt_idle", {31'b0, bus.mem_rd}, 32'h0);
      if ($urandom_range(0, 1) == 1) begin
        redirect    = 1'b1;
        redirect_pc = 8'($urandom_range(0, 255));
        m_pc        = redirect_pc;
      end
      repeat (2) step();
      check("halt_still_idle", {31'b0, bus.mem_rd}, 32'h0);
      check("halt_pc", {24'b0, bus.pc_out}, {24'b0, m_pc});
      halt = 1'b0;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    halt          = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 8'h00;
    bus.mem_ready = 1'b0;
    bus.ack_in    = 1'b0;
    model_reset();
    #12;
    check("reset_data", {16'b0, bus.data_out}, 32'h0);
    check("reset_ph1", {30'b0, bus.ph1_out}, 32'h0);
    check("reset_mem_rd", {31'b0, bus.mem_rd}, 32'h0);
    check("reset_pc_out", {24'b0, bus.pc_out}, {24'b0, RESET_PC});
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int w = 0; w < 3; w++) do_word(1'b0, 1'b0);
    for (int w = 0; w < 40; w++) do_word(1'b1, w == 20);
    for (int w = 0; w < 3; w++) do_word(1'b0, 1'b0);
    repeat (12) step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
